// File: rtl/dec_arb_pkg.sv
// Shared types and defaults for the decoder-select arbiter.
// Imported by rr_pick4 and dec_sel_arbiter.
package dec_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam int DEF_MIN_DWELL = 4;
  localparam int DEF_GUARD_CYC = 1;
  localparam int DEF_MAX_HOLD  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    GUARD = 2'd3
  } arbState_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set req
// searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import dec_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    any   = |req;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_sel_arbiter.sv
// Round-robin owner of a 2-to-4 decoder: min dwell, guard gap.
// Optional forced release after MAX_HOLD under ARB_TIMEOUT_EN.
module dec_sel_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MIN_DWELL = DEF_MIN_DWELL,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int MAX_HOLD  = DEF_MAX_HOLD
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               sel_b,
  output logic               sel_a,
  output logic               sel_vld,
  output logic               busy,
  output logic               timeout
);

  if (MIN_DWELL < 1 || MIN_DWELL > 255 ||
      GUARD_CYC < 1 || GUARD_CYC > 15 ||
      MAX_HOLD <= MIN_DWELL || MAX_HOLD > 255) begin : gBadCfg
    $fatal(1, "dec_sel_arbiter: parameter out of range");
  end

  localparam logic [7:0] DWELL_END = 8'(MIN_DWELL);
  localparam logic [3:0] GUARD_END = 4'(GUARD_CYC);

  arbState_e        state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pickIdx;
  logic             pickAny;
  logic             ownerRel;
  logic             guardDone;
  logic             startGrant;
  logic [7:0]       holdCnt;
  logic [3:0]       guardCnt;

  rr_pick4 uPick (
    .req (req),
    .ptr (ptr),
    .any (pickAny),
    .idx (pickIdx)
  );

  assign ownerRel   = rel[owner];
  assign guardDone  = (state == GUARD) && (guardCnt == GUARD_END);
  assign startGrant = pickAny && ((state == IDLE) || guardDone);

`ifdef ARB_TIMEOUT_EN
  // holdCnt lags the grant cycle number by one once in HOLD
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic holdExpired;
  logic timeoutQ;
  assign holdExpired = holdCnt == HOLD_LAST;
  assign timeout     = timeoutQ;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      sel_vld  <= 1'b0;
      ptr      <= 2'd3;
      holdCnt  <= '0;
      guardCnt <= '0;
`ifdef ARB_TIMEOUT_EN
      timeoutQ <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeoutQ <= 1'b0;
`endif
      if (startGrant) begin
        state    <= GRANT;
        gnt      <= 4'b0001 << pickIdx;
        owner    <= pickIdx;
        sel_vld  <= 1'b1;
        ptr      <= pickIdx;
        holdCnt  <= 8'd1;
        guardCnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          GRANT: begin
            if (holdCnt == DWELL_END) begin
              state <= HOLD;
            end else begin
              holdCnt <= holdCnt + 8'd1;
            end
          end
          HOLD: begin
            if (ownerRel) begin
              state    <= GUARD;
              gnt      <= '0;
              sel_vld  <= 1'b0;
              guardCnt <= 4'd1;
`ifdef ARB_TIMEOUT_EN
            end else if (holdExpired) begin
              state    <= GUARD;
              gnt      <= '0;
              sel_vld  <= 1'b0;
              guardCnt <= 4'd1;
              timeoutQ <= 1'b1;
            end else begin
              holdCnt <= holdCnt + 8'd1;
`endif
            end
          end
          GUARD: begin
            if (guardDone) begin
              state <= IDLE;
            end else begin
              guardCnt <= guardCnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign sel_b = owner[1];
  assign sel_a = owner[0];
  assign busy  = state != IDLE;

endmodule

// File: tb/tb_dec_sel_arbiter.sv
// Scoreboard bench for dec_sel_arbiter.
// Build with +define+ARB_TIMEOUT_EN to exercise forced release.
module tb_dec_sel_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 16;
`else
  localparam int TB_MAX_HOLD = 64;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic [3:0] gnt;
  logic       sel_b;
  logic       sel_a;
  logic       sel_vld;
  logic       busy;
  logic       timeout;

  int         compared   = 0;
  int         mismatched = 0;
  logic [3:0] expQ[$];
  logic [3:0] expG;

  always #5 clk = ~clk;

  dec_sel_arbiter #(
    .MIN_DWELL (4),
    .GUARD_CYC (1),
    .MAX_HOLD  (TB_MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .sel_b   (sel_b),
    .sel_a   (sel_a),
    .sel_vld (sel_vld),
    .busy    (busy),
    .timeout (timeout)
  );

  function automatic logic [1:0] idxOf(input logic [3:0] g);
    idxOf = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) idxOf = 2'(i);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      compared++;
      if (!$onehot0(gnt) || sel_vld !== (|gnt) ||
          (sel_vld && {sel_b, sel_a} !== idxOf(gnt))) begin
        mismatched++;
        $display("FAIL invariant: gnt=%b sel_vld=%b sel=%b%b",
                 gnt, sel_vld, sel_b, sel_a);
      end
`ifndef ARB_TIMEOUT_EN
      compared++;
      if (timeout !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_tied: got %b want 0", timeout);
      end
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok  = 1'b0;
    req = '0;
    for (int i = 0; i < 40; i++) begin
      rel = gnt;
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    rel = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = '0;
    rel = '0;
    repeat (2) tick();
    compared++;
    if ({gnt, sel_b, sel_a, sel_vld, busy, timeout} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_vals: got %b want 0",
               {gnt, sel_b, sel_a, sel_vld, busy, timeout});
    end
    rst = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      mismatched++;
      $display("FAIL idle_no_req: busy=%b gnt=%b want 0/0", busy, gnt);
    end
  endtask

  task automatic test_single;
    req = 4'b0100;
    expQ.push_back(4'b0100);
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL single_gnt: got %b want %b", gnt, expG);
    end
    compared++;
    if ({sel_b, sel_a, sel_vld} !== 3'b101) begin
      mismatched++;
      $display("FAIL single_sel: got %b want 101",
               {sel_b, sel_a, sel_vld});
    end
    repeat (4) tick();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++;
      $display("FAIL single_hold: got %b want 0100", gnt);
    end
    rel = 4'b0100;
    tick();
    rel = '0;
    compared++;
    if (gnt !== 4'b0 || sel_vld !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_rel: gnt=%b vld=%b busy=%b want 0/0/1",
               gnt, sel_vld, busy);
    end
    compared++;
    if ({sel_b, sel_a} !== 2'b10) begin
      mismatched++;
      $display("FAIL guard_sel: got %b want 10", {sel_b, sel_a});
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_early_release;
    req = 4'b0100;
    expQ.push_back(4'b0100);
    tick();
    req = '0;
    rel = 4'b0100;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL early_gnt: got %b want %b", gnt, expG);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      compared++;
      if (gnt !== 4'b0100) begin
        mismatched++;
        $display("FAIL early_dwell c%0d: got %b want 0100", c, gnt);
      end
    end
    tick();
    compared++;
    if (gnt !== 4'b0) begin
      mismatched++;
      $display("FAIL early_rel: got %b want 0000", gnt);
    end
    rel = '0;
    tick();
  endtask

  task automatic test_fairness;
    int         got;
    int         cyc;
    logic [3:0] prevG;
    bit         ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0010);
    expQ.push_back(4'b0100);
    expQ.push_back(4'b1000);
    expQ.push_back(4'b0001);
    got   = 0;
    cyc   = 0;
    prevG = '0;
    while (got < 5 && cyc < 100) begin
      tick();
      cyc++;
      if (gnt !== 4'b0 && gnt !== prevG) begin
        expG = expQ.pop_front();
        compared++;
        if (gnt !== expG) begin
          mismatched++;
          $display("FAIL fair_order #%0d: got %b want %b",
                   got, gnt, expG);
        end
        compared++;
        if (prevG !== 4'b0) begin
          mismatched++;
          $display("FAIL fair_gap: prev %b now %b want gap",
                   prevG, gnt);
        end
        got++;
      end
      prevG = gnt;
      rel   = gnt;
    end
    compared++;
    if (got != 5) begin
      mismatched++;
      $display("FAIL fair_count: got %0d grants want 5", got);
    end
    expQ.delete();
    drain(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL fair_drain: busy got %b want 0", busy);
    end
  endtask

  task automatic test_non_owner;
    bit ok;
    req = 4'b0010;
    expQ.push_back(4'b0010);
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL nonown_gnt: got %b want %b", gnt, expG);
    end
    repeat (4) tick();
    rel = 4'b1000;
    for (int c = 6; c <= 7; c++) begin
      tick();
      compared++;
      if (gnt !== 4'b0010) begin
        mismatched++;
        $display("FAIL nonown_rel c%0d: got %b want 0010", c, gnt);
      end
    end
    rel = 4'b0010;
    req = 4'b1000;
    expQ.push_back(4'b1000);
    tick();
    rel = '0;
    compared++;
    if (gnt !== 4'b0) begin
      mismatched++;
      $display("FAIL rel_first: got %b want 0000", gnt);
    end
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL after_guard: got %b want %b", gnt, expG);
    end
    drain(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL nonown_drain: busy got %b want 0", busy);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    req = 4'b0100;
    expQ.push_back(4'b0100);
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL arst_pre: got %b want %b", gnt, expG);
    end
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (gnt !== 4'b0 || sel_vld !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL arst_now: gnt=%b vld=%b busy=%b want 0",
               gnt, sel_vld, busy);
    end
    req = 4'b1101;
    expQ.push_back(4'b0001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL arst_ptr: got %b want %b", gnt, expG);
    end
    drain(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL arst_drain: busy got %b want 0", busy);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0101;
    expQ.push_back(4'b0001);
    expQ.push_back(4'b0100);
    tick();
    req = 4'b0100;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL to_gnt: got %b want %b", gnt, expG);
    end
    for (int c = 2; c <= 16; c++) begin
      tick();
      compared++;
      if ({gnt, timeout} !== 5'b00010) begin
        mismatched++;
        $display("FAIL to_hold c%0d: gnt=%b to=%b want 0001/0",
                 c, gnt, timeout);
      end
    end
    tick();
    compared++;
    if (gnt !== 4'b0 || timeout !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL to_force: gnt=%b to=%b busy=%b want 0/1/1",
               gnt, timeout, busy);
    end
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL to_next: gnt=%b to=%b want %b/0",
               gnt, timeout, expG);
    end
    drain(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL to_drain: busy got %b want 0", busy);
    end
  endtask
`else
  task automatic test_hold_forever;
    bit ok;
    req = 4'b0001;
    expQ.push_back(4'b0001);
    tick();
    req = '0;
    expG = expQ.pop_front();
    compared++;
    if (gnt !== expG) begin
      mismatched++;
      $display("FAIL forever_gnt: got %b want %b", gnt, expG);
    end
    repeat (80) tick();
    compared++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL forever_hold: gnt=%b busy=%b want 0001/1",
               gnt, busy);
    end
    drain(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL forever_drain: busy got %b want 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_early_release();
    test_fairness();
    test_non_owner();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_left: got %0d want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dec_sel_arbiter.md
Name: dec_sel_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-4 decoded resource among 4 requesters.
- Drives the decoder's two select inputs (sel_b = MSB, sel_a = LSB) with the current owner's index.
- Holds each grant for a minimum dwell, then releases on request.
- Inserts a guard gap between owners so two decoded outputs are never switched back-to-back without an idle cycle.

Parameters:
- MIN_DWELL, 4: minimum cycles a grant is held before release is honoured (1..255).
- GUARD_CYC, 1: idle cycles between release and next grant (1..15).
- MAX_HOLD, 64: timeout in cycles; used only when ARB_TIMEOUT_EN is defined (MAX_HOLD > MIN_DWELL).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  request per requester; level, held until granted.
- rel  in  4  release per requester; sampled only from the current owner.
- gnt  out 4  one-hot grant; registered.
- sel_b  out 1  decoder select MSB = owner[1].
- sel_a  out 1  decoder select LSB = owner[0].
- sel_vld  out 1  high while sel_b/sel_a carry a granted index.
- busy  out 1  high in any state other than IDLE.
- timeout  out 1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE.
  - gnt = 0, sel_b = 0, sel_a = 0, sel_vld = 0, busy = 0, timeout = 0.
  - Round-robin pointer ptr = 3, so requester 0 has top priority first.
  - Counters = 0.
- FSM states: IDLE, GRANT, HOLD, GUARD.
- IDLE:
  - If |req, pick the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4). Call it w.
  - Next cycle: state = GRANT, gnt = 1<<w, {sel_b, sel_a} = w, sel_vld = 1, ptr = w, dwell counter = 1.
  - Latency from req high to gnt high is 1 cycle.
- GRANT (counting the minimum dwell):
  - Counter increments each cycle.
  - rel[w] is ignored in this state.
  - When counter == MIN_DWELL, go to HOLD.
- HOLD:
  - If rel[w] == 1: next cycle gnt = 0, sel_vld = 0, state = GUARD, guard counter = 1.
  - rel from any non-owner is ignored.
  - req[w] dropping without rel does not release the grant.
- GUARD:
  - gnt = 0, sel_vld = 0.
  - sel_b/sel_a hold the last owner's index (keeps the decoder input stable).
  - After GUARD_CYC cycles: go to IDLE if no req; otherwise arbitrate directly using the IDLE rule, with the same 1-cycle grant latency.
- Simultaneous events:
  - Multiple req: round-robin order from ptr+1.
  - rel[w] together with new requests: release first; new grant only after the guard.
  - rel[w] arriving in GRANT on the same cycle counter reaches MIN_DWELL: not honoured; it must still be high in HOLD.
- Invariants:
  - gnt is one-hot or zero at all times.
  - sel_vld == |gnt.
  - {sel_b, sel_a} == index of the set gnt bit whenever sel_vld = 1.
- Reset asserted mid-grant: all outputs drop to reset values asynchronously; no guard is applied.
- Counter widths: 8-bit dwell/hold counter, 4-bit guard counter; no wrap occurs within the legal parameter ranges.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter continues to count in HOLD.
  - If the total grant length reaches MAX_HOLD without rel[w], the arbiter force-releases: enters GUARD and pulses timeout for 1 cycle, aligned with gnt falling.
  - ptr still advances to w, so the offender loses priority.
- Undefined:
  - A grant is held indefinitely until rel[w].
  - The timeout port exists but is constant 0.

Decomposition:
- Package dec_arb_pkg:
  - State enum (IDLE, GRANT, HOLD, GUARD).
  - NUM_REQ = 4, IDX_W = 2.
  - Default constants for MIN_DWELL, GUARD_CYC, MAX_HOLD.
- Sub-module rr_pick4:
  - Combinational round-robin selector.
  - Inputs: req[3:0], ptr[1:0]. Outputs: any, idx[1:0].
  - Instantiated once; reusable by other arbiters.

Test Plan:
- Single requester: req = 4'b0100 at cycle 0.
  - Expect gnt = 4'b0100, sel_b = 1, sel_a = 0, sel_vld = 1 at cycle 1.
  - Assert rel[2] at cycle 5 (default MIN_DWELL = 4) → gnt = 0 at cycle 6, busy low after GUARD_CYC.
- Early release: rel[2] held from cycle 1.
  - Expect gnt held through GRANT (cycles 1–4).
  - Release only when HOLD is reached: gnt = 0 at the first HOLD cycle + 1.
- Fairness: req = 4'b1111 constant, each owner releases immediately in HOLD.
  - Expect grant order 0, 1, 2, 3, 0, with ≥ 1 cycle of sel_vld = 0 between grants.
- Non-owner release: owner 1, pulse rel[3] → no change.
  - Then pulse rel[1] → release.
- Async reset mid-HOLD: assert rst between clock edges.
  - Expect gnt = 0, sel_vld = 0, busy = 0 immediately, with no clock edge needed.
  - After release with req = 4'b0001: grant 0 first.
- ARB_TIMEOUT_EN with MAX_HOLD = 16: owner 0 never releases.
  - Expect gnt drop and a single timeout pulse at grant cycle 16.
  - Then grant goes to the next requester after the guard.
